// File: rtl/rgmii_tx_framer.sv
// RGMII transmit framer: wraps a byte stream with preamble, SFD, optional pad, FCS and IFG,
// then drives the pins through SAME_EDGE DDR output registers. Padding enabled by RGMII_TX_PAD_EN.
module rgmii_tx_framer #(
    parameter int IFG_BYTES      = 12,
    parameter int PREAMBLE_BYTES = 7,
    parameter int MIN_FRAME      = 60
) (
    input  logic       tx_clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic       tx_ctl,
    output logic [3:0] tx_data,
    output logic       busy,
    output logic       underrun
);

`ifdef RGMII_TX_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, IFG} state_t;

    state_t      state, state_nxt;
    logic [15:0] timer, timer_nxt;
    logic [15:0] cnt, cnt_nxt, cnt_inc;
    logic [31:0] crc, crc_nxt;
    logic [7:0]  byte_nxt, txd;
    logic        en_nxt, er_nxt, underrun_nxt;
    logic        tx_en, tx_er;
    logic [4:0]  ddr_rise, ddr_fall;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    assign busy    = (state != IDLE);

    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        cnt_nxt      = cnt;
        crc_nxt      = crc;
        byte_nxt     = 8'h00;
        en_nxt       = 1'b0;
        er_nxt       = 1'b0;
        underrun_nxt = 1'b0;
        s_ready      = 1'b0;
        case (state)
            IDLE: begin
                if (s_valid) begin
                    state_nxt = PRE;
                    timer_nxt = 16'(PREAMBLE_BYTES - 1);
                    cnt_nxt   = 16'd0;
                    crc_nxt   = 32'hFFFF_FFFF;
                end
            end
            PRE: begin
                byte_nxt = 8'h55;
                en_nxt   = 1'b1;
                if (timer == 16'd0) state_nxt = SFD;
                else                timer_nxt = timer - 16'd1;
            end
            SFD: begin
                byte_nxt  = 8'hD5;
                en_nxt    = 1'b1;
                state_nxt = DATA;
            end
            DATA: begin
                en_nxt  = 1'b1;
                s_ready = s_valid;
                if (s_valid) begin
                    byte_nxt = s_data;
                    crc_nxt  = crc_step(crc, s_data);
                    cnt_nxt  = cnt_inc;
                    if (s_last) begin
                        timer_nxt = 16'd3;
                        if (PAD_ON && ((32'(cnt) + 32'd1) < MIN_FRAME)) state_nxt = PAD;
                        else                                           state_nxt = FCS;
                    end
                end else begin
                    // source starved mid-frame: poison the byte and abandon the frame
                    er_nxt       = 1'b1;
                    underrun_nxt = 1'b1;
                    state_nxt    = IFG;
                    timer_nxt    = 16'(IFG_BYTES - 1);
                end
            end
            PAD: begin
                en_nxt  = 1'b1;
                crc_nxt = crc_step(crc, 8'h00);
                cnt_nxt = cnt_inc;
                if ((32'(cnt) + 32'd1) >= MIN_FRAME) begin
                    state_nxt = FCS;
                    timer_nxt = 16'd3;
                end
            end
            FCS: begin
                en_nxt   = 1'b1;
                byte_nxt = ~crc[7:0];
                crc_nxt  = {8'hFF, crc[31:8]};
                if (timer == 16'd0) begin
                    state_nxt = IFG;
                    timer_nxt = 16'(IFG_BYTES - 1);
                end else begin
                    timer_nxt = timer - 16'd1;
                end
            end
            IFG: begin
                if (timer != 16'd0) begin
                    timer_nxt = timer - 16'd1;
                end else if (s_valid) begin
                    // back-to-back: skip the IDLE cycle so the gap stays exactly IFG_BYTES
                    state_nxt = PRE;
                    timer_nxt = 16'(PREAMBLE_BYTES - 1);
                    cnt_nxt   = 16'd0;
                    crc_nxt   = 32'hFFFF_FFFF;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            timer    <= 16'd0;
            cnt      <= 16'd0;
            crc      <= 32'hFFFF_FFFF;
            txd      <= 8'h00;
            tx_en    <= 1'b0;
            tx_er    <= 1'b0;
            underrun <= 1'b0;
            ddr_rise <= 5'd0;
            ddr_fall <= 5'd0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            cnt      <= cnt_nxt;
            crc      <= crc_nxt;
            txd      <= byte_nxt;
            tx_en    <= en_nxt;
            tx_er    <= er_nxt;
            underrun <= underrun_nxt;
            ddr_rise <= {tx_en, txd[3:0]};
            ddr_fall <= {tx_en ^ tx_er, txd[7:4]};
        end
    end

    // SAME_EDGE DDR: both halves captured on the rising edge, high phase shows the rising half
    assign {tx_ctl, tx_data} = tx_clk ? ddr_rise : ddr_fall;

endmodule
